// File: rtl/prio_encoder_pipe.sv
// Pipelined priority encoder / request arbiter with LSB-first, MSB-first and
// round-robin priority, valid/ready flow control and an explicit no-request result.
module prio_encoder_pipe #(
    parameter  int WIDTH   = 8,
    parameter  int LATENCY = 2,
    localparam int IDXW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    input  logic             rr_mode,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_none
);

    logic             w_en;
    logic             w_accept;
    logic             w_any;
    logic [WIDTH-1:0] w_rot;
    logic [IDXW-1:0]  w_lsb_idx;
    logic [IDXW-1:0]  w_msb_idx;
    logic [IDXW:0]    w_rr_off;
    logic [IDXW:0]    w_rr_sum;
    logic [IDXW-1:0]  w_rr_idx;
    logic [IDXW-1:0]  w_idx;
    logic [WIDTH-1:0] w_onehot;

    logic [IDXW-1:0]  r_ptr;
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_none;
    logic [IDXW-1:0]  r_idx    [LATENCY];
    logic [WIDTH-1:0] r_onehot [LATENCY];

    assign out_valid  = r_vld[LATENCY-1];
    assign out_idx    = r_idx[LATENCY-1];
    assign out_onehot = r_onehot[LATENCY-1];
    assign out_none   = r_none[LATENCY-1];

    // Whole pipeline advances or holds as one; no bubble collapsing.
    assign w_en     = out_ready || !out_valid;
    assign in_ready = w_en;
    assign w_accept = in_valid && w_en;
    assign w_any    = |in_req;
    assign w_rot    = WIDTH'({in_req, in_req} >> r_ptr);

    // Scan for the lowest, highest and pointer-relative first set bit.
    always_comb begin
        w_lsb_idx = '0;
        w_msb_idx = '0;
        w_rr_off  = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            w_lsb_idx = in_req[k] ? IDXW'(k) : w_lsb_idx;
            w_rr_off  = w_rot[k] ? (IDXW + 1)'(k) : w_rr_off;
        end
        for (int k = 0; k < WIDTH; k++) begin
            w_msb_idx = in_req[k] ? IDXW'(k) : w_msb_idx;
        end
    end

    // Resolve the winner for the active mode and build the grant vector.
    always_comb begin
        w_rr_sum = {1'b0, r_ptr} + w_rr_off;
        if (w_rr_sum >= (IDXW + 1)'(WIDTH)) begin
            w_rr_idx = IDXW'(w_rr_sum - (IDXW + 1)'(WIDTH));
        end else begin
            w_rr_idx = w_rr_sum[IDXW-1:0];
        end
        if (!w_any) begin
            w_idx = '0;
        end else if (rr_mode) begin
            w_idx = w_rr_idx;
        end else if (msb_first) begin
            w_idx = w_msb_idx;
        end else begin
            w_idx = w_lsb_idx;
        end
        w_onehot = w_any ? ({{(WIDTH-1){1'b0}}, 1'b1} << w_idx) : '0;
    end

    // Round-robin pointer moves past the winner only on an accepted, non-empty RR request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept && rr_mode && w_any) begin
            r_ptr <= (w_idx == IDXW'(WIDTH - 1)) ? '0 : w_idx + IDXW'(1);
        end
    end

    // Result pipeline; data fields are cleared whenever their valid bit is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_none <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_idx[s]    <= '0;
                r_onehot[s] <= '0;
            end
        end else if (w_en) begin
            r_vld[0]    <= in_valid;
            r_none[0]   <= in_valid && !w_any;
            r_idx[0]    <= in_valid ? w_idx : '0;
            r_onehot[0] <= in_valid ? w_onehot : '0;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s]    <= r_vld[s-1];
                r_none[s]   <= r_none[s-1];
                r_idx[s]    <= r_idx[s-1];
                r_onehot[s] <= r_onehot[s-1];
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Directed bench for prio_encoder_pipe (WIDTH=8, LATENCY=2) with an in-order
// result queue of hand-computed expectations.
module tb_prio_encoder_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_req;
    logic       rr_mode;
    logic       msb_first;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic       out_none;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q [$];

    prio_encoder_pipe #(.WIDTH(8), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_req     (in_req),
        .rr_mode    (rr_mode),
        .msb_first  (msb_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_none   (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Offer one transaction (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic push(input logic [7:0] req, input logic rr, input logic msb,
                        input logic [2:0] idx, input logic none);
        int guard;
        guard     = 0;
        in_valid  = 1'b1;
        in_req    = req;
        rr_mode   = rr;
        msb_first = msb;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk_eq("accept_timeout", in_ready, 1'b1);
        else exp_q.push_back({none, idx});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Output monitor: each consumed result must match the oldest expectation.
    always @(negedge clk) begin
        logic [3:0] e;
        logic [7:0] oh;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk_eq("spurious_out", out_valid, 1'b0);
            end else begin
                e  = exp_q.pop_front();
                oh = e[3] ? 8'h00 : (8'h01 << e[2:0]);
                chk_eq("idx", out_idx, e[2:0]);
                chk_eq("onehot", out_onehot, oh);
                chk_eq("none", out_none, e[3]);
            end
        end else if (!rst && !out_valid) begin
            chk_eq("idle_zero", {out_idx, out_onehot, out_none}, 12'h000);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint t0;
        rst = 1'b1; in_valid = 1'b0; in_req = 8'h00; rr_mode = 1'b0;
        msb_first = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("rst_valid", out_valid, 1'b0);
        chk_eq("rst_fields", {out_idx, out_onehot, out_none}, 12'h000);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Fixed LSB, latency of exactly one cycle after acceptance edge
        push(8'b1010_0100, 1'b0, 1'b0, 3'd2, 1'b0);
        @(negedge clk); chk_eq("lat_e0", out_valid, 1'b0);
        @(negedge clk); chk_eq("lat_e1", out_valid, 1'b1);
        @(negedge clk); chk_eq("lat_e2", out_valid, 1'b0);
        @(posedge clk); #1;

        // Back-to-back fixed-mode vectors, including the empty request
        t0 = $time;
        push(8'b1010_0100, 1'b0, 1'b0, 3'd2, 1'b0);
        push(8'b0010_0110, 1'b0, 1'b1, 3'd5, 1'b0);
        push(8'b0010_0110, 1'b0, 1'b0, 3'd1, 1'b0);
        push(8'h00,        1'b0, 1'b0, 3'd0, 1'b1);
        push(8'h00,        1'b0, 1'b1, 3'd0, 1'b1);
        chk_eq("b2b_time", $time - t0, 64'd50);
        repeat (3) @(posedge clk); #1;

        // Round-robin from ptr=0: 0..7,0,1
        for (int i = 0; i < 10; i++) push(8'hFF, 1'b1, 1'b0, 3'(i % 8), 1'b0);
        push(8'h00,        1'b1, 1'b0, 3'd0, 1'b1);   // ptr stays 2
        push(8'hFF,        1'b1, 1'b0, 3'd2, 1'b0);   // ptr -> 3
        push(8'b1000_0001, 1'b1, 1'b0, 3'd7, 1'b0);   // ptr -> 0
        push(8'b1000_0001, 1'b1, 1'b0, 3'd0, 1'b0);   // ptr -> 1
        push(8'b1000_0001, 1'b0, 1'b1, 3'd7, 1'b0);   // fixed, ptr stays 1
        push(8'hFF,        1'b1, 1'b0, 3'd1, 1'b0);   // ptr -> 2
        repeat (3) @(posedge clk); #1;
        chk_eq("drain_rr", exp_q.size(), 0);

        // Backpressure: three offers while downstream stalls
        out_ready = 1'b0;
        push(8'hF0, 1'b0, 1'b0, 3'd4, 1'b0);
        push(8'hF0, 1'b0, 1'b1, 3'd7, 1'b0);
        fork
            push(8'h0C, 1'b1, 1'b0, 3'd2, 1'b0);      // ptr 2 -> 3
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk_eq("stall_valid", out_valid, 1'b1);
                    chk_eq("stall_idx", out_idx, 3'd4);
                    chk_eq("stall_onehot", out_onehot, 8'h10);
                    chk_eq("stall_ready", in_ready, 1'b0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        chk_eq("drain_stall", exp_q.size(), 0);

        // Asynchronous reset with two results in flight
        push(8'hFF, 1'b1, 1'b0, 3'd3, 1'b0);          // ptr -> 4
        push(8'hFF, 1'b1, 1'b0, 3'd4, 1'b0);          // ptr -> 5
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        chk_eq("arst_valid", out_valid, 1'b0);
        chk_eq("arst_fields", {out_idx, out_onehot, out_none}, 12'h000);
        chk_eq("arst_ready", in_ready, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_eq("no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        push(8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);          // ptr was cleared
        repeat (3) @(posedge clk); #1;
        chk_eq("drain_end", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prio_encoder_pipe.md
Name: prio_encoder_pipe

Overview:
- Parametrised, pipelined priority encoder / request arbiter; successor to the fixed 4-bit, single-register encoder.
- Generalised in request width and pipeline depth.
- Adds:
  - run-time selectable LSB-first, MSB-first or round-robin priority;
  - valid/ready flow control with backpressure;
  - a defined "no request" result.
- Sits between request-collecting logic and downstream grant/dispatch logic.

Parameters:
- WIDTH, 8, number of request lines; legal range 2..64, not required to be a power of two.
- LATENCY, 2, register stages from input acceptance to output; legal range 1..4.
- IDXW, clog2(WIDTH), width of the index output; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  in_req/mode inputs are valid this cycle.
- in_ready  out  1  block can accept this cycle.
- in_req  in  WIDTH  request vector; bit i = request from line i.
- rr_mode  in  1  1 = round-robin priority; 0 = fixed priority.
- msb_first  in  1  fixed mode only: 1 = highest index wins; 0 = lowest index wins. Ignored when rr_mode=1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_idx  out  IDXW  winning index.
- out_onehot  out  WIDTH  one-hot grant vector, equal to 1<<out_idx, or 0 when out_none.
- out_none  out  1  the accepted in_req was all-zero.

Behaviour:
- Accept condition: in_valid && in_ready.
- in_ready = out_ready || !out_valid. This is a global pipeline enable: all stages shift together when it is 1 and hold when it is 0. No bubble collapsing.
- Stage 0 is combinational from in_req, rr_mode, msb_first and the RR pointer. Its result passes through LATENCY register stages, each carrying a valid bit.
- Latency: a transaction accepted at edge N appears on the outputs after edge N+LATENCY-1 (visible in cycle N+LATENCY-1 onward) when no stall occurs.
- Fixed, LSB-first: lowest set bit wins (same priority as the previous encoder).
- Fixed, MSB-first: highest set bit wins.
- Round-robin:
  - Search starts at pointer ptr, proceeds upward, wraps from WIDTH-1 to 0; the first set bit wins.
  - On an accepted transaction with a winner, ptr <= (idx+1), with WIDTH-1 wrapping to 0. This holds for non-power-of-2 WIDTH.
  - ptr is unchanged on stall, when the transaction is not accepted, in fixed mode, and on an all-zero request.
- All-zero request: out_none=1, out_idx=0, out_onehot=0, out_valid=1 (the transaction still completes).
- Mode bits are sampled only at acceptance. A mode change mid-stream affects only later transactions. Results already in flight are unaffected.
- Stall: while out_valid && !out_ready, all of out_* and all internal stages hold exactly. No transaction is dropped or duplicated.
- Reset (asynchronous, any time including mid-operation):
  - all stage valids = 0, out_valid = 0, out_idx = 0, out_onehot = 0, out_none = 0, ptr = 0;
  - in-flight transactions are discarded;
  - in_ready = 1 after reset deasserts.
- Output fields are 0 whenever out_valid=0 (data registers clear alongside valid).
- Throughput: 1 transaction/cycle with out_ready held high.

Test Plan:
- WIDTH=8, LATENCY=2, fixed LSB: in_req=8'b1010_0100 -> out_idx=2, onehot=8'h04, out_none=0, out_valid exactly 1 cycle after acceptance edge; back-to-back inputs give back-to-back outputs.
- Fixed MSB: in_req=8'b0010_0110 with msb_first=1 -> out_idx=5, onehot=8'h20; same vector with msb_first=0 -> out_idx=1.
- in_req=8'h00 in any mode -> out_valid=1, out_none=1, out_idx=0, onehot=0; RR ptr unchanged (next in_req=8'hFF still grants the same index as before).
- RR, in_req=8'hFF for 10 consecutive accepts from reset -> idx sequence 0,1,...,7,0,1. in_req=8'b1000_0001 with ptr=3 -> idx=7, then next accept -> idx=0.
- Backpressure: out_ready=0 for 5 cycles with 3 transactions offered -> in_ready drops once out_valid=1; outputs are stable throughout; after release, results emerge in order with no loss or duplication.
- Assert rst asynchronously (between edges) with 2 transactions in flight -> out_valid=0 and ptr=0 immediately; no stale result appears after rst deasserts.
